// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue path.
//   - SEL_*   : 4-bit select codes understood by the combinational ALU
//   - FUNCT_* : 6-bit MIPS R-type funct values that map onto those codes
//   - state_t : issue controller FSM states
package alu_pkg;

  localparam logic [3:0] SEL_NOP  = 4'b0000;
  localparam logic [3:0] SEL_ADD  = 4'b0001;
  localparam logic [3:0] SEL_SUB  = 4'b0010;
  localparam logic [3:0] SEL_MULT = 4'b0011;
  localparam logic [3:0] SEL_DIV  = 4'b0100;
  localparam logic [3:0] SEL_AND  = 4'b0101;
  localparam logic [3:0] SEL_OR   = 4'b0110;
  localparam logic [3:0] SEL_NOR  = 4'b0111;
  localparam logic [3:0] SEL_SLT  = 4'b1000;
  localparam logic [3:0] SEL_XOR  = 4'b1001;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_EXEC  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational MIPS R-type funct -> ALU select decode.
// Ports:
//   funct   in  6  R-type funct field
//   sel     out 4  ALU select code (SEL_NOP when illegal)
//   illegal out 1  funct has no ALU operation
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] sel,
  output logic       illegal
);

  // funct lookup; anything outside the table is flagged illegal
  always_comb begin
    sel     = SEL_NOP;
    illegal = 1'b0;
    case (funct)
      FUNCT_ADD:  sel = SEL_ADD;
      FUNCT_SUB:  sel = SEL_SUB;
      FUNCT_MULT: sel = SEL_MULT;
      FUNCT_DIV:  sel = SEL_DIV;
      FUNCT_AND:  sel = SEL_AND;
      FUNCT_OR:   sel = SEL_OR;
      FUNCT_NOR:  sel = SEL_NOR;
      FUNCT_SLT:  sel = SEL_SLT;
      FUNCT_XOR:  sel = SEL_XOR;
      default: begin
        sel     = SEL_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one R-type op at a time to a combinational ALU that
// only re-evaluates when its Sel input changes. Operands are registered
// first, Sel is pulsed from NOP to the op code, and Res/zero_flag are
// captured SETTLE_CYCLES later and returned over a valid/ready response.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       request handshake (in_ready only in IDLE)
//   funct, op_a, op_b       request payload
//   alu_A, alu_B, alu_Sel   registered drive to the ALU
//   alu_Res, alu_zero       ALU outputs
//   out_valid/out_ready     response handshake
//   result, zero            captured ALU result and zero flag
//   illegal, div_by_zero    error flags, valid with out_valid
module alu_issue_ctrl #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_Sel,
  input  logic [DATA_W-1:0] alu_Res,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal,
  output logic              div_by_zero
);
  import alu_pkg::*;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        op_sel, op_sel_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              in_ready_nx, out_valid_nx;
  logic [DATA_W-1:0] alu_a_nx, alu_b_nx, result_nx;
  logic [3:0]        alu_sel_nx;
  logic              zero_nx, illegal_nx, div_by_zero_nx;

  logic [3:0]        dec_sel;
  logic              dec_illegal;
  logic              dec_div_zero;

  alu_funct_decode u_decode (
    .funct   (funct),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  assign dec_div_zero = (dec_sel == SEL_DIV) && (op_b == '0);

  // next-state and next-output computation; every register holds by default
  always_comb begin
    state_nx       = state;
    op_sel_nx      = op_sel;
    cnt_nx         = cnt;
    in_ready_nx    = in_ready;
    out_valid_nx   = out_valid;
    alu_a_nx       = alu_A;
    alu_b_nx       = alu_B;
    alu_sel_nx     = alu_Sel;
    result_nx      = result;
    zero_nx        = zero;
    illegal_nx     = illegal;
    div_by_zero_nx = div_by_zero;

    case (state)
      ST_IDLE: begin
        alu_sel_nx = SEL_NOP;
        if (in_valid && in_ready) begin
          alu_a_nx    = op_a;
          alu_b_nx    = op_b;
          op_sel_nx   = dec_sel;
          in_ready_nx = 1'b0;
          if (dec_illegal) begin
            // answered immediately; the ALU is never exercised
            result_nx      = '0;
            zero_nx        = 1'b1;
            illegal_nx     = 1'b1;
            div_by_zero_nx = 1'b0;
            out_valid_nx   = 1'b1;
            state_nx       = ST_RESP;
          end else if (dec_div_zero) begin
            result_nx      = '0;
            zero_nx        = 1'b1;
            illegal_nx     = 1'b0;
            div_by_zero_nx = 1'b1;
            out_valid_nx   = 1'b1;
            state_nx       = ST_RESP;
          end else begin
            state_nx = ST_SETUP;
          end
        end else begin
          in_ready_nx = 1'b1;
          state_nx    = ST_IDLE;
        end
      end

      ST_SETUP: begin
        // operands have been stable for a cycle; the Sel edge triggers the ALU
        alu_sel_nx = op_sel;
        cnt_nx     = 4'd0;
        state_nx   = ST_EXEC;
      end

      ST_EXEC: begin
        if (cnt == SETTLE_LAST) begin
          result_nx      = alu_Res;
          zero_nx        = alu_zero;
          illegal_nx     = 1'b0;
          div_by_zero_nx = 1'b0;
          alu_sel_nx     = SEL_NOP;
          out_valid_nx   = 1'b1;
          state_nx       = ST_RESP;
        end else begin
          cnt_nx   = cnt + 4'd1;
          state_nx = ST_EXEC;
        end
      end

      ST_RESP: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          in_ready_nx  = 1'b1;
          state_nx     = ST_IDLE;
        end else begin
          out_valid_nx = 1'b1;
          state_nx     = ST_RESP;
        end
      end

      default: begin
        state_nx     = ST_IDLE;
        in_ready_nx  = 1'b1;
        out_valid_nx = 1'b0;
        alu_sel_nx   = SEL_NOP;
      end
    endcase
  end

  // state and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_sel      <= SEL_NOP;
      cnt         <= 4'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_Sel     <= SEL_NOP;
      result      <= '0;
      zero        <= 1'b0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nx;
      op_sel      <= op_sel_nx;
      cnt         <= cnt_nx;
      in_ready    <= in_ready_nx;
      out_valid   <= out_valid_nx;
      alu_A       <= alu_a_nx;
      alu_B       <= alu_b_nx;
      alu_Sel     <= alu_sel_nx;
      result      <= result_nx;
      zero        <= zero_nx;
      illegal     <= illegal_nx;
      div_by_zero <= div_by_zero_nx;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a Sel-edge-sensitive ALU model is
// attached, the driver pushes expected responses from a reference model and
// an independent monitor pops and compares whenever a response is offered.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int SETTLE = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        funct = 6'd0;
  logic [DATA_W-1:0] op_a = '0;
  logic [DATA_W-1:0] op_b = '0;
  logic [DATA_W-1:0] alu_A, alu_B;
  logic [3:0]        alu_Sel;
  logic [DATA_W-1:0] alu_res = '0;
  logic              alu_zf = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] result;
  logic              zero, illegal, div_by_zero;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  int     rdy_mode = 0;      // 0: always ready, 1: random, 2: never
  bit     in_reset = 1'b1;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic        dz;
    logic [3:0]  sel;
    int          pulses;
    int          lat;
    longint      acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl #(.DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .op_a(op_a), .op_b(op_b),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Sel(alu_Sel),
    .alu_Res(alu_res), .alu_zero(alu_zf),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .div_by_zero(div_by_zero)
  );

  // ALU model that only re-evaluates when Sel changes
  always @(alu_Sel) begin
    case (alu_Sel)
      SEL_ADD:  alu_res = alu_A + alu_B;
      SEL_SUB:  alu_res = alu_A - alu_B;
      SEL_MULT: alu_res = alu_A * alu_B;
      SEL_DIV:  alu_res = (alu_B == 32'd0) ? 32'd0 : alu_A / alu_B;
      SEL_AND:  alu_res = alu_A & alu_B;
      SEL_OR:   alu_res = alu_A | alu_B;
      SEL_NOR:  alu_res = ~(alu_A | alu_B);
      SEL_SLT:  alu_res = ($signed(alu_A) < $signed(alu_B)) ? 32'd1 : 32'd0;
      SEL_XOR:  alu_res = alu_A ^ alu_B;
      default:  alu_res = 32'd0;
    endcase
    alu_zf = (alu_res == 32'd0);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // expected response straight from the funct table and operation semantics
  function automatic exp_t ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = 32'd0; e.ill = 1'b0; e.dz = 1'b0; e.sel = 4'd0; e.acc_cyc = 0;
    case (f)
      6'h20: begin e.sel = 4'd1; e.res = a + b; end
      6'h22: begin e.sel = 4'd2; e.res = a - b; end
      6'h18: begin e.sel = 4'd3; e.res = a * b; end
      6'h1A: begin e.sel = 4'd4; if (b == 32'd0) e.dz = 1'b1; else e.res = a / b; end
      6'h24: begin e.sel = 4'd5; e.res = a & b; end
      6'h25: begin e.sel = 4'd6; e.res = a | b; end
      6'h27: begin e.sel = 4'd7; e.res = ~(a | b); end
      6'h2A: begin e.sel = 4'd8; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      6'h26: begin e.sel = 4'd9; e.res = a ^ b; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill || e.dz) begin
      e.res = 32'd0; e.zero = 1'b1; e.sel = 4'd0; e.pulses = 0; e.lat = 1;
    end else begin
      e.zero = (e.res == 32'd0); e.pulses = SETTLE; e.lat = SETTLE + 2;
    end
    return e;
  endfunction

  // out_ready is updated shortly after the rising edge so the monitor sees its final value
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // monitor: tracks Sel pulses, checks latency/stability and pops the scoreboard
  bit          seen_valid = 1'b0;
  bit          expect_ready = 1'b0;
  int          sel_pulses = 0;
  logic [3:0]  sel_seen = 4'd0;
  logic [34:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (in_reset) begin
      seen_valid = 1'b0; expect_ready = 1'b0; sel_pulses = 0; sel_seen = 4'd0;
    end else begin
      if (expect_ready) begin
        chk("in_ready_after_resp", {63'd0, in_ready}, 64'd1);
        expect_ready = 1'b0;
      end
      if (alu_Sel != 4'd0) begin
        sel_pulses++;
        sel_seen = alu_Sel;
      end
      if (out_valid) begin
        chk("in_ready_low_in_resp", {63'd0, in_ready}, 64'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_response", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb_q[0];
          if (!seen_valid) begin
            chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat - 1));
            held = {result, zero, illegal, div_by_zero};
            seen_valid = 1'b1;
          end else begin
            chk("resp_held_stable", {29'd0, result, zero, illegal, div_by_zero}, {29'd0, held});
          end
          if (out_ready) begin
            void'(sb_q.pop_front());
            chk("result", {32'd0, result}, {32'd0, e.res});
            chk("zero", {63'd0, zero}, {63'd0, e.zero});
            chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
            chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
            chk("sel_code", {60'd0, sel_seen}, {60'd0, e.sel});
            chk("sel_pulse_cycles", 64'(sel_pulses), 64'(e.pulses));
            seen_valid = 1'b0; sel_pulses = 0; sel_seen = 4'd0;
            expect_ready = 1'b1;
          end
        end
      end
    end
  end

  // called at a falling edge; holds the request until accepted, then scrambles inputs
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    in_valid = 1'b1; funct = f; op_a = a; op_b = b;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e = ref_model(f, a, b);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    funct = 6'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(negedge clk);
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_alu_A"}, {32'd0, alu_A}, 64'd0);
    chk({tag, "_alu_B"}, {32'd0, alu_B}, 64'd0);
    chk({tag, "_alu_Sel"}, {60'd0, alu_Sel}, 64'd0);
    chk({tag, "_result"}, {32'd0, result}, 64'd0);
    chk({tag, "_flags"}, {61'd0, zero, illegal, div_by_zero}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  legal [9];
    logic [5:0]  f;
    logic [31:0] a, b;
    int          pick;
    legal = '{6'h20, 6'h22, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;
    @(negedge clk);

    // directed cases
    rdy_mode = 0;
    issue(6'h20, 32'd5, 32'd7);
    drain();
    issue(6'h22, 32'd9, 32'd9);
    issue(6'h22, 32'd10, 32'd3);
    drain();
    issue(6'h1A, 32'd77, 32'd0);
    drain();
    issue(6'h3F, 32'd1, 32'd2);
    issue(6'h2A, 32'd3, 32'd4);
    drain();

    // backpressure: response must hold while out_ready stays low
    rdy_mode = 2;
    repeat (3) @(negedge clk);
    issue(6'h18, 32'd6, 32'd7);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_result", {32'd0, result}, 64'd42);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    rdy_mode = 0;
    drain();

    // reset while the XOR is in EXEC: no response may appear
    issue(6'h26, 32'hF0F0_1234, 32'h0FF0_4321);
    @(negedge clk);
    chk("xor_sel_in_exec", {60'd0, alu_Sel}, 64'd9);
    in_reset = 1'b1;
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_reset_vals("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;
    repeat (5) @(negedge clk);
    issue(6'h20, 32'd1, 32'd1);
    drain();

    // randomized traffic with random backpressure and gaps
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 11);
      a = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
      b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
      if (pick < 9) begin
        f = legal[pick];
      end else if (pick == 9) begin
        f = 6'h1A;
        b = 32'd0;
      end else begin
        f = 6'($urandom);
      end
      issue(f, a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
